// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a datapath payload and a control payload.
// The producer side uses master; the consumer side uses slave.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 12
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, registered handshake outputs
// and synchronous flush that turns held entries into control bubbles.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 96,
    parameter int unsigned       CTRL_W      = 12,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    pipe_stage_skid_if.slave         up,
    pipe_stage_skid_if.master        dn,
    output logic [1:0]               occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q;
    logic              valid_q;
    logic              ready_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    logic acc;
    logic del;

    // ready_q is a flop, so neither dn.ready nor up.valid reaches up.ready.
    assign acc = up.valid & ready_q & ~flush;
    assign del = valid_q & dn.ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
        end else if (flush) begin
            // Data fields keep their old contents; only control is forced safe.
            state_q     <= StEmpty;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_ctrl_q <= CTRL_BUBBLE;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        main_data_q <= up.data;
                        main_ctrl_q <= up.ctrl;
                        valid_q     <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (acc && del) begin
                        main_data_q <= up.data;
                        main_ctrl_q <= up.ctrl;
                    end else if (acc) begin
                        skid_data_q <= up.data;
                        skid_ctrl_q <= up.ctrl;
                        ready_q     <= 1'b0;
                        state_q     <= StFull;
                    end else if (del) begin
                        valid_q     <= 1'b0;
                        main_ctrl_q <= CTRL_BUBBLE;
                        state_q     <= StEmpty;
                    end
                end
                StFull: begin
                    if (del) begin
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        ready_q     <= 1'b1;
                        state_q     <= StOne;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    valid_q     <= 1'b0;
                    ready_q     <= 1'b1;
                    main_ctrl_q <= CTRL_BUBBLE;
                end
            endcase
        end
    end

    assign up.ready  = ready_q;
    assign dn.valid  = valid_q;
    assign dn.data   = main_data_q;
    assign dn.ctrl   = main_ctrl_q;
    assign occupancy = state_q;

endmodule
